dvs_event_scheduler: RTL and testbench

Front-end scheduler for the MLP denoiser activation path. It buffers incoming CAVIAR events with their timestamps in a small FIFO and issues them one at a time to the activation builder. Each issue uses a one-cycle valid pulse, and the next event is held back until the builder's `done`. The block also owns the shared timestamp memory's port-1 controls: after reset it sweeps the whole DVS array writing zero timestamps, then hands the port to the builder.

---
 rtl/dvs_event_scheduler_if.sv | 42 ++++
 rtl/dvs_event_scheduler.sv | 145 ++++++++++++++
 tb/tb_dvs_event_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvs_event_scheduler_if.sv
// Event input, activation-builder and memory port-1 bundle for dvs_event_scheduler.
// slave is the scheduler's view; master is the event source / builder / memory side.
interface dvs_event_scheduler_if #(
   parameter int CAVIAR_X_Y_BITS = 9,
   parameter int TIMESTAMP_BITS  = 16,
   parameter int WORD_SIZE       = 18,
   parameter int FIFO_DEPTH      = 8
);
   logic [2*CAVIAR_X_Y_BITS:0]   ev_in;
   logic [TIMESTAMP_BITS-1:0]    ev_ts;
   logic                         ev_vld;
   logic                         ev_rdy;
   logic [2*CAVIAR_X_Y_BITS:0]   act_cavier;
   logic [TIMESTAMP_BITS-1:0]    act_timestamp;
   logic                         act_vld;
   logic                         act_done;
   logic                         act_rw;
   logic                         act_cen;
   logic [CAVIAR_X_Y_BITS-1:0]   act_addr_x;
   logic [CAVIAR_X_Y_BITS-1:0]   act_addr_y;
   logic [WORD_SIZE-1:0]         act_wdata;
   logic                         mem_rw;
   logic                         mem_cen;
   logic [CAVIAR_X_Y_BITS-1:0]   mem_addr_x;
   logic [CAVIAR_X_Y_BITS-1:0]   mem_addr_y;
   logic [WORD_SIZE-1:0]         mem_wdata;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   logic                         mem_init_done;
   logic                         busy;

   modport slave (
      input  ev_in, ev_ts, ev_vld, act_done, act_rw, act_cen, act_addr_x, act_addr_y, act_wdata,
      output ev_rdy, act_cavier, act_timestamp, act_vld, mem_rw, mem_cen, mem_addr_x, mem_addr_y,
             mem_wdata, fifo_count, mem_init_done, busy
   );

   modport master (
      output ev_in, ev_ts, ev_vld, act_done, act_rw, act_cen, act_addr_x, act_addr_y, act_wdata,
      input  ev_rdy, act_cavier, act_timestamp, act_vld, mem_rw, mem_cen, mem_addr_x, mem_addr_y,
             mem_wdata, fifo_count, mem_init_done, busy
   );
endinterface

// File: rtl/dvs_event_scheduler.sv
// Buffers CAVIAR events and issues them one at a time to the activation builder; owns memory port 1.
// Define SCHED_MEM_CLEAR_EN to add the post-reset zero-timestamp sweep of the DVS array.
module dvs_event_scheduler #(
   parameter int CAVIAR_X_Y_BITS = 9,
   parameter int TIMESTAMP_BITS  = 16,
   parameter int WORD_SIZE       = 18,
   parameter int FIFO_DEPTH      = 8,
   parameter int DVS_WIDTH       = 346,
   parameter int DVS_HEIGHT      = 260
) (
   input logic                  clk,
   input logic                  rst_n,
   dvs_event_scheduler_if.slave bus
);
   localparam int EV_W    = 2*CAVIAR_X_Y_BITS + 1;
   localparam int ENTRY_W = EV_W + TIMESTAMP_BITS;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("dvs_event_scheduler: FIFO_DEPTH must be a power of two >= 2");
   end
   if (DVS_WIDTH < 1 || DVS_HEIGHT < 1 ||
       DVS_WIDTH > 2**CAVIAR_X_Y_BITS || DVS_HEIGHT > 2**CAVIAR_X_Y_BITS) begin : g_dvs_check
      $error("dvs_event_scheduler: DVS extent does not fit the coordinate width");
   end

   typedef enum logic [1:0] {CLEAR, IDLE, ISSUE, WAIT} state_t;

`ifdef SCHED_MEM_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t                state, state_nxt;
   logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  ev_rdy, push, pop, fifo_empty;
   logic [EV_W-1:0]       cav_q;
   logic [TIMESTAMP_BITS-1:0] ts_q;

   assign fifo_empty = (count == '0);
   assign ev_rdy     = (count < CNT_W'(FIFO_DEPTH));
   assign push       = bus.ev_vld & ev_rdy;
   // The head is loaded exactly when the FSM leaves IDLE/WAIT for ISSUE.
   assign pop        = !fifo_empty && ((state == IDLE) || (state == WAIT && bus.act_done));

   assign bus.ev_rdy        = ev_rdy;
   assign bus.fifo_count    = count;
   assign bus.act_cavier    = cav_q;
   assign bus.act_timestamp = ts_q;

`ifdef SCHED_MEM_CLEAR_EN
   localparam logic [CAVIAR_X_Y_BITS-1:0] X_LAST = CAVIAR_X_Y_BITS'(DVS_WIDTH - 1);
   localparam logic [CAVIAR_X_Y_BITS-1:0] Y_LAST = CAVIAR_X_Y_BITS'(DVS_HEIGHT - 1);

   logic [CAVIAR_X_Y_BITS-1:0] clr_x, clr_y;
   logic                       clr_last;

   assign clr_last = (clr_x == X_LAST) && (clr_y == Y_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_x <= '0;
         clr_y <= '0;
      end else if (state == CLEAR) begin
         if (clr_x == X_LAST) begin
            clr_x <= '0;
            clr_y <= clr_y + CAVIAR_X_Y_BITS'(1);
         end else begin
            clr_x <= clr_x + CAVIAR_X_Y_BITS'(1);
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= RESET_STATE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
`ifdef SCHED_MEM_CLEAR_EN
         CLEAR: if (clr_last) state_nxt = IDLE;
`else
         CLEAR: state_nxt = IDLE;
`endif
         IDLE:  if (!fifo_empty) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (bus.act_done) state_nxt = fifo_empty ? IDLE : ISSUE;
      endcase
   end

   always_comb begin
      bus.act_vld    = (state == ISSUE);
      bus.busy       = (state != IDLE) || !fifo_empty;
      bus.mem_rw     = bus.act_rw;
      bus.mem_cen    = bus.act_cen;
      bus.mem_addr_x = bus.act_addr_x;
      bus.mem_addr_y = bus.act_addr_y;
      bus.mem_wdata  = bus.act_wdata;
`ifdef SCHED_MEM_CLEAR_EN
      bus.mem_init_done = (state != CLEAR);
      if (state == CLEAR) begin
         bus.mem_rw     = 1'b1;
         bus.mem_cen    = 1'b1;
         bus.mem_addr_x = clr_x;
         bus.mem_addr_y = clr_y;
         bus.mem_wdata  = '0;
      end
`else
      bus.mem_init_done = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cav_q  <= '0;
         ts_q   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr        <= rd_ptr + PTR_W'(1);
            {cav_q, ts_q} <= fifo_mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {bus.ev_in, bus.ev_ts};
   end
endmodule

// File: tb/tb_dvs_event_scheduler.sv
// Directed bench for dvs_event_scheduler with a reduced 4x3 DVS array.
// Covers reset, clear sweep (when SCHED_MEM_CLEAR_EN), issue timing, back-to-back, full FIFO, spurious done and mid-run reset.
module tb_dvs_event_scheduler;
   localparam int XY    = 9;
   localparam int TSB   = 16;
   localparam int WS    = 18;
   localparam int DEPTH = 8;
   localparam int W     = 4;
   localparam int H     = 3;
`ifdef SCHED_MEM_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   tests  = 0;
   int   failed = 0;
   logic [2*XY:0]  f_ev [10];
   logic [TSB-1:0] f_ts [10];

   dvs_event_scheduler_if #(
      .CAVIAR_X_Y_BITS(XY), .TIMESTAMP_BITS(TSB), .WORD_SIZE(WS), .FIFO_DEPTH(DEPTH)
   ) bus ();

   dvs_event_scheduler #(
      .CAVIAR_X_Y_BITS(XY), .TIMESTAMP_BITS(TSB), .WORD_SIZE(WS), .FIFO_DEPTH(DEPTH),
      .DVS_WIDTH(W), .DVS_HEIGHT(H)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*XY:0] mk_ev(input int x, input int y, input bit p);
      return {XY'(x), XY'(y), p};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [2*XY:0] ev, input logic [TSB-1:0] ts);
      bus.ev_in  = ev;
      bus.ev_ts  = ts;
      bus.ev_vld = 1'b1;
   endtask

   task automatic pulse_done();
      bus.act_done = 1'b1;
      step();
      bus.act_done = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.ev_in      = '0;
      bus.ev_ts      = '0;
      bus.ev_vld     = 1'b0;
      bus.act_done   = 1'b0;
      bus.act_rw     = 1'b0;
      bus.act_cen    = 1'b0;
      bus.act_addr_x = '0;
      bus.act_addr_y = '0;
      bus.act_wdata  = '0;

      // Reset state
      step();
      step();
      check_output("rst_act_vld", bus.act_vld, 0);
      check_output("rst_act_cavier", bus.act_cavier, 0);
      check_output("rst_act_ts", bus.act_timestamp, 0);
      check_output("rst_count", bus.fifo_count, 0);
      check_output("rst_ev_rdy", bus.ev_rdy, 1);
      check_output("rst_init_done", bus.mem_init_done, !CLEAR_EN);
      check_output("rst_busy", bus.busy, CLEAR_EN);
      rst_n = 1'b1;

`ifdef SCHED_MEM_CLEAR_EN
      // Clear sweep overrides builder controls; event A pushed mid-sweep
      bus.act_wdata  = 18'h3ffff;
      bus.act_addr_x = 9'h1ff;
      bus.act_addr_y = 9'h1ff;
      for (int i = 0; i < W*H; i++) begin
         check_output($sformatf("clr_cen_%0d", i), bus.mem_cen, 1);
         check_output($sformatf("clr_rw_%0d", i), bus.mem_rw, 1);
         check_output($sformatf("clr_x_%0d", i), bus.mem_addr_x, i % W);
         check_output($sformatf("clr_y_%0d", i), bus.mem_addr_y, i / W);
         check_output($sformatf("clr_wdata_%0d", i), bus.mem_wdata, 0);
         check_output($sformatf("clr_init_%0d", i), bus.mem_init_done, 0);
         check_output($sformatf("clr_vld_%0d", i), bus.act_vld, 0);
         check_output($sformatf("clr_count_%0d", i), bus.fifo_count, (i >= 3) ? 1 : 0);
         if (i == 2) apply_stimulus(mk_ev(2, 3, 0), 16'h0abc);
         else        bus.ev_vld = 1'b0;
         step();
      end
      bus.act_wdata  = '0;
      bus.act_addr_x = '0;
      bus.act_addr_y = '0;
      check_output("clr_done_init", bus.mem_init_done, 1);
      check_output("clr_done_vld", bus.act_vld, 0);
      step();
      check_output("clr_ev_vld", bus.act_vld, 1);
      check_output("clr_ev_cav", bus.act_cavier, mk_ev(2, 3, 0));
      check_output("clr_ev_ts", bus.act_timestamp, 16'h0abc);
      step();
      pulse_done();
`else
      step();
      check_output("noclr_init", bus.mem_init_done, 1);
`endif
      check_output("idle_busy", bus.busy, 0);

      // Memory passthrough outside CLEAR
      bus.act_rw     = 1'b1;
      bus.act_cen    = 1'b1;
      bus.act_addr_x = 9'h123;
      bus.act_addr_y = 9'h0ab;
      bus.act_wdata  = 18'h2a5a5;
      #1;
      check_output("pt_rw", bus.mem_rw, 1);
      check_output("pt_cen", bus.mem_cen, 1);
      check_output("pt_x", bus.mem_addr_x, 9'h123);
      check_output("pt_y", bus.mem_addr_y, 9'h0ab);
      check_output("pt_wdata", bus.mem_wdata, 18'h2a5a5);
      bus.act_rw     = 1'b0;
      bus.act_cen    = 1'b0;
      bus.act_addr_x = '0;
      bus.act_addr_y = '0;
      bus.act_wdata  = '0;

      // Single event: pulse one edge after acceptance, no repeat before done
      apply_stimulus(mk_ev(5, 7, 1), 16'h1234);
      step();
      bus.ev_vld = 1'b0;
      check_output("single_pre_vld", bus.act_vld, 0);
      check_output("single_count", bus.fifo_count, 1);
      step();
      check_output("single_vld", bus.act_vld, 1);
      check_output("single_cav", bus.act_cavier, 19'h140f);
      check_output("single_ts", bus.act_timestamp, 16'h1234);
      check_output("single_count0", bus.fifo_count, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_output($sformatf("single_hold_vld_%0d", i), bus.act_vld, 0);
         check_output($sformatf("single_hold_cav_%0d", i), bus.act_cavier, 19'h140f);
      end
      pulse_done();
      check_output("single_busy", bus.busy, 0);

      // Spurious done while IDLE
      bus.act_done = 1'b1;
      step();
      bus.act_done = 1'b0;
      check_output("spur_idle_vld", bus.act_vld, 0);
      check_output("spur_idle_count", bus.fifo_count, 0);
      check_output("spur_idle_busy", bus.busy, 0);

      // Spurious done during ISSUE is ignored; machine still reaches WAIT
      apply_stimulus(mk_ev(9, 1, 0), 16'h00b0);
      step();
      bus.ev_vld = 1'b0;
      step();
      check_output("spur_issue_vld", bus.act_vld, 1);
      bus.act_done = 1'b1;
      step();
      bus.act_done = 1'b0;
      check_output("spur_issue_vld0", bus.act_vld, 0);
      check_output("spur_issue_busy", bus.busy, 1);

      // Back-to-back: three events queued while WAIT
      for (int i = 0; i < 3; i++) begin
         f_ev[i] = mk_ev(10 + i, 20 + i, i[0]);
         f_ts[i] = 16'hc000 + 16'(i);
         apply_stimulus(f_ev[i], f_ts[i]);
         step();
      end
      bus.ev_vld = 1'b0;
      check_output("b2b_count3", bus.fifo_count, 3);
      check_output("b2b_wait_vld", bus.act_vld, 0);
      for (int i = 0; i < 3; i++) begin
         pulse_done();
         check_output($sformatf("b2b_vld_%0d", i), bus.act_vld, 1);
         check_output($sformatf("b2b_cav_%0d", i), bus.act_cavier, f_ev[i]);
         check_output($sformatf("b2b_ts_%0d", i), bus.act_timestamp, f_ts[i]);
         check_output($sformatf("b2b_count_%0d", i), bus.fifo_count, 2 - i);
         step();
         check_output($sformatf("b2b_vld0_%0d", i), bus.act_vld, 0);
      end
      pulse_done();
      check_output("b2b_idle_busy", bus.busy, 0);

      // Full FIFO: F0 issues, F1..F8 fill all eight slots, F9 is held off
      for (int i = 0; i < 10; i++) begin
         f_ev[i] = mk_ev(100 + i, 200 + 3*i, ~i[0]);
         f_ts[i] = 16'h5000 + 16'(17*i);
      end
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(f_ev[i], f_ts[i]);
         step();
      end
      check_output("full_count", bus.fifo_count, 8);
      check_output("full_rdy", bus.ev_rdy, 0);
      check_output("full_head", bus.act_cavier, f_ev[0]);
      apply_stimulus(f_ev[9], f_ts[9]);
      for (int i = 0; i < 3; i++) begin
         step();
         check_output($sformatf("full_hold_count_%0d", i), bus.fifo_count, 8);
         check_output($sformatf("full_hold_rdy_%0d", i), bus.ev_rdy, 0);
         check_output($sformatf("full_hold_vld_%0d", i), bus.act_vld, 0);
      end
      pulse_done();
      check_output("full_pop_vld", bus.act_vld, 1);
      check_output("full_pop_cav", bus.act_cavier, f_ev[1]);
      check_output("full_pop_count", bus.fifo_count, 7);
      check_output("full_pop_rdy", bus.ev_rdy, 1);
      step();
      bus.ev_vld = 1'b0;
      check_output("full_refill_count", bus.fifo_count, 8);
      for (int i = 2; i < 10; i++) begin
         pulse_done();
         check_output($sformatf("full_drain_vld_%0d", i), bus.act_vld, 1);
         check_output($sformatf("full_drain_cav_%0d", i), bus.act_cavier, f_ev[i]);
         check_output($sformatf("full_drain_ts_%0d", i), bus.act_timestamp, f_ts[i]);
         check_output($sformatf("full_drain_count_%0d", i), bus.fifo_count, 9 - i);
         step();
      end
      pulse_done();
      check_output("full_idle_busy", bus.busy, 0);

      // Mid-operation reset in WAIT with four events buffered
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(mk_ev(50 + i, 60 + i, 1), 16'h7700 + 16'(i));
         step();
      end
      bus.ev_vld = 1'b0;
      check_output("mrst_pre_count", bus.fifo_count, 4);
      check_output("mrst_pre_busy", bus.busy, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_output("mrst_vld", bus.act_vld, 0);
      check_output("mrst_count", bus.fifo_count, 0);
      check_output("mrst_cav", bus.act_cavier, 0);
      check_output("mrst_ts", bus.act_timestamp, 0);
      check_output("mrst_init", bus.mem_init_done, !CLEAR_EN);
      check_output("mrst_busy", bus.busy, CLEAR_EN);
      for (int i = 0; i < 15; i++) begin
         step();
         check_output($sformatf("mrst_quiet_vld_%0d", i), bus.act_vld, 0);
         check_output($sformatf("mrst_quiet_count_%0d", i), bus.fifo_count, 0);
      end
      check_output("mrst_end_init", bus.mem_init_done, 1);
      check_output("mrst_end_busy", bus.busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
